// File: rtl/proc_pkg.sv
// Shared encodings for the 16-bit processor: opcodes, bus selects,
// branch conditions, ALU ops and control sequencer states.
package proc_pkg;

  localparam logic [2:0] OP_MV      = 3'b000;
  localparam logic [2:0] OP_MVT_BRN = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_LD      = 3'b100;
  localparam logic [2:0] OP_ST      = 3'b101;
  localparam logic [2:0] OP_AND     = 3'b110;
  localparam logic [2:0] OP_CMP     = 3'b111;

  localparam logic [3:0] SEL_R0  = 4'd0;
  localparam logic [3:0] SEL_R1  = 4'd1;
  localparam logic [3:0] SEL_R2  = 4'd2;
  localparam logic [3:0] SEL_R3  = 4'd3;
  localparam logic [3:0] SEL_R4  = 4'd4;
  localparam logic [3:0] SEL_R5  = 4'd5;
  localparam logic [3:0] SEL_R6  = 4'd6;
  localparam logic [3:0] SEL_R7  = 4'd7;
  localparam logic [3:0] SEL_IMM = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;
  localparam logic [3:0] SEL_G   = 4'd10;

  localparam logic [2:0] CC_AL = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_NE = 3'b010;
  localparam logic [2:0] CC_CC = 3'b011;
  localparam logic [2:0] CC_CS = 3'b100;
  localparam logic [2:0] CC_PL = 3'b101;
  localparam logic [2:0] CC_MI = 3'b110;
  localparam logic [2:0] CC_NV = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_F2   = 3'd3,
    ST_E1   = 3'd4,
    ST_E2   = 3'd5,
    ST_E3   = 3'd6
  } state_e;

  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  function automatic logic [3:0] reg_sel(input logic [2:0] idx);
    return {1'b0, idx};
  endfunction

  function automatic logic [1:0] alu_of(input logic [2:0] op);
    logic [1:0] a;
    a = ALU_ADD;
    case (op)
      OP_SUB:  a = ALU_SUB;
      OP_CMP:  a = ALU_SUB;
      OP_AND:  a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/proc_cond_eval.sv
// Branch condition evaluator: decides whether a b{cond} is taken
// from the condition field and the registered ALU flags.
module proc_cond_eval
  import proc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       c,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    unique case (cond)
      CC_AL: take = 1'b1;
      CC_EQ: take = z;
      CC_NE: take = ~z;
      CC_CC: take = ~c;
      CC_CS: take = c;
      CC_PL: take = ~n;
      CC_MI: take = n;
      CC_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Fetch/execute control sequencer: drives the bus mux select and all
// datapath load enables from the current state and the decoded IR.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter logic [2:0] PC_REG  = 3'd7,
  parameter int         MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        z,
  input  logic        n,
  input  logic        c,
  output logic [3:0]  sel,
  output logic [7:0]  r_in,
  output logic        ir_in,
  output logic        a_in,
  output logic        g_in,
  output logic        f_in,
  output logic [1:0]  alu_op,
  output logic        addr_in,
  output logic        dout_in,
  output logic        w_d,
  output logic        inc_pc,
  output logic        done
);

  if (MEM_LAT != 1) begin : g_bad_lat
    $error("proc_ctrl_fsm: only MEM_LAT=1 is supported");
  end

  state_e state_q, state_d;

  logic [2:0] op;
  logic       imm;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [3:0] op2;
  logic       take;

  assign op  = ir[15:13];
  assign imm = ir[12];
  assign rx  = ir[11:9];
  assign ry  = ir[2:0];
  assign op2 = imm ? SEL_IMM : reg_sel(ry);

  // The immediate payload is routed by the bus mux, not used here.
  logic unused_imm;
  assign unused_imm = ^ir[8:3];

  proc_cond_eval u_cond (
    .cond (rx),
    .z    (z),
    .n    (n),
    .c    (c),
    .take (take)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sel     = SEL_R0;
    r_in    = 8'h00;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    f_in    = 1'b0;
    alu_op  = ALU_ADD;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    inc_pc  = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_F0;
      end
      ST_F0: begin
        sel     = reg_sel(PC_REG);
        addr_in = 1'b1;
        state_d = ST_F1;
      end
      ST_F1: begin
        inc_pc  = 1'b1;
        state_d = ST_F2;
      end
      ST_F2: begin
        sel     = SEL_DIN;
        ir_in   = 1'b1;
        state_d = ST_E1;
      end
      ST_E1: begin
        case (op)
          OP_MV: begin
            sel  = op2;
            r_in = reg_onehot(rx);
            done = 1'b1;
          end
          OP_MVT_BRN: begin
            if (imm) begin
              sel  = SEL_IMM;
              r_in = reg_onehot(rx);
              done = 1'b1;
            end else if (take) begin
              sel     = reg_sel(PC_REG);
              a_in    = 1'b1;
              state_d = ST_E2;
            end else begin
              done = 1'b1;
            end
          end
          OP_LD, OP_ST: begin
            sel     = reg_sel(ry);
            addr_in = 1'b1;
            state_d = ST_E2;
          end
          default: begin
            sel     = reg_sel(rx);
            a_in    = 1'b1;
            state_d = ST_E2;
          end
        endcase
      end
      ST_E2: begin
        case (op)
          OP_MVT_BRN: begin
            sel     = SEL_IMM;
            alu_op  = ALU_ADD;
            g_in    = 1'b1;
            state_d = ST_E3;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel     = op2;
            alu_op  = alu_of(op);
            g_in    = 1'b1;
            f_in    = 1'b1;
            state_d = ST_E3;
          end
          OP_CMP: begin
            sel    = op2;
            alu_op = ALU_SUB;
            f_in   = 1'b1;
            done   = 1'b1;
          end
          OP_LD: begin
            state_d = ST_E3;
          end
          OP_ST: begin
            sel     = reg_sel(rx);
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_E3: begin
        case (op)
          OP_MVT_BRN: begin
            sel  = SEL_G;
            r_in = reg_onehot(PC_REG);
            done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel  = SEL_G;
            r_in = reg_onehot(rx);
            done = 1'b1;
          end
          OP_LD: begin
            sel  = SEL_DIN;
            r_in = reg_onehot(rx);
            done = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // run is only honoured at instruction end; it never aborts one.
    if (done) state_d = run ? ST_F0 : ST_IDLE;
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: driver queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_proc_ctrl_fsm;

  logic        clk;
  logic        resetn;
  logic        run;
  logic [15:0] ir;
  logic        z, n, c;
  logic [3:0]  sel;
  logic [7:0]  r_in;
  logic        ir_in, a_in, g_in, f_in;
  logic [1:0]  alu_op;
  logic        addr_in, dout_in, w_d, inc_pc, done;

  proc_ctrl_fsm dut (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run),
    .ir      (ir),
    .z       (z),
    .n       (n),
    .c       (c),
    .sel     (sel),
    .r_in    (r_in),
    .ir_in   (ir_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .f_in    (f_in),
    .alu_op  (alu_op),
    .addr_in (addr_in),
    .dout_in (dout_in),
    .w_d     (w_d),
    .inc_pc  (inc_pc),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] IR   = 11'h400;
  localparam logic [10:0] A    = 11'h200;
  localparam logic [10:0] G    = 11'h100;
  localparam logic [10:0] F    = 11'h080;
  localparam logic [10:0] AND_ = 11'h040;
  localparam logic [10:0] SUB  = 11'h020;
  localparam logic [10:0] ADDR = 11'h010;
  localparam logic [10:0] DOUT = 11'h008;
  localparam logic [10:0] W    = 11'h004;
  localparam logic [10:0] INC  = 11'h002;
  localparam logic [10:0] DONE = 11'h001;

  typedef struct {
    string       nm;
    logic [22:0] v;
  } exp_t;

  exp_t sbq[$];
  exp_t pend[$];
  int   vectors;
  int   miscompares;
  bit   idle;

  logic [22:0] act;
  assign act = {sel, r_in, ir_in, a_in, g_in, f_in, alu_op,
                addr_in, dout_in, w_d, inc_pc, done};

  function automatic logic [22:0] o(input logic [3:0] s,
                                    input logic [7:0] r,
                                    input logic [10:0] en);
    return {s, r, en};
  endfunction

  function automatic exp_t mk(input string nm, input logic [22:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.v);
      end
    end
  end

  task automatic tick(input string nm, input logic [22:0] v);
    sbq.push_back(mk(nm, v));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input string nm, input int cnt);
    run = 1'b0;
    for (int i = 0; i < cnt; i++) tick(nm, '0);
  endtask

  task automatic ex(input logic [22:0] v);
    pend.push_back(mk("", v));
  endtask

  // One instruction: optional IDLE cycle, fetch, then queued exec cycles.
  task automatic go(input string nm, input logic [15:0] irv,
                    input logic [2:0] znc, input bit run_end,
                    input bit drop);
    exp_t seq[$];
    int   first_ex;
    if (idle) seq.push_back(mk({nm, "_idle"}, '0));
    seq.push_back(mk({nm, "_f0"}, o(4'd7, 8'h00, ADDR)));
    seq.push_back(mk({nm, "_f1"}, o(4'd0, 8'h00, INC)));
    seq.push_back(mk({nm, "_f2"}, o(4'd9, 8'h00, IR)));
    first_ex = seq.size();
    for (int i = 0; i < pend.size(); i++)
      seq.push_back(mk($sformatf("%s_e%0d", nm, i + 1), pend[i].v));
    pend.delete();
    for (int k = 0; k < seq.size(); k++) begin
      ir        = irv;
      {z, n, c} = znc;
      if (k == seq.size() - 1)        run = run_end;
      else if (drop && k >= first_ex) run = 1'b0;
      else                            run = 1'b1;
      sbq.push_back(seq[k]);
      @(posedge clk);
      #1;
    end
    idle = !run_end;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    run         = 1'b0;
    ir          = 16'h0000;
    {z, n, c}   = 3'b000;
    idle        = 1'b1;
    @(posedge clk);
    #1;
    tick("reset", '0);
    resetn = 1'b1;

    // Reset asserted while in F2 drops everything in the same cycle.
    ir  = 16'h4201;
    run = 1'b1;
    tick("rst_idle", '0);
    tick("rst_f0", o(4'd7, 8'h00, ADDR));
    tick("rst_f1", o(4'd0, 8'h00, INC));
    resetn = 1'b0;
    tick("rst_in_f2", '0);
    resetn = 1'b1;
    idle_cycles("rst_hold_idle", 10);

    ex(o(4'd8, 8'h20, DONE));
    go("mv_imm", 16'h1A05, 3'b000, 1'b1, 1'b0);

    ex(o(4'd1, 8'h00, A));
    ex(o(4'd1, 8'h00, G | F));
    ex(o(4'd10, 8'h02, DONE));
    go("add", 16'h4201, 3'b000, 1'b1, 1'b0);

    ex(o(4'd0, 8'h00, DONE));
    go("beq_nt", 16'h2200, 3'b000, 1'b1, 1'b0);

    ex(o(4'd7, 8'h00, A));
    ex(o(4'd8, 8'h00, G));
    ex(o(4'd10, 8'h80, DONE));
    go("beq_t", 16'h2200, 3'b100, 1'b1, 1'b0);

    ex(o(4'd3, 8'h00, ADDR));
    ex(o(4'd0, 8'h00, 11'h000));
    ex(o(4'd9, 8'h02, DONE));
    go("ld", 16'h8203, 3'b000, 1'b1, 1'b0);

    ex(o(4'd3, 8'h00, ADDR));
    ex(o(4'd1, 8'h00, DOUT | W | DONE));
    go("st", 16'hA203, 3'b000, 1'b1, 1'b0);

    ex(o(4'd2, 8'h00, A));
    ex(o(4'd5, 8'h00, G | F | SUB));
    ex(o(4'd10, 8'h04, DONE));
    go("sub", 16'h6405, 3'b000, 1'b1, 1'b0);

    ex(o(4'd3, 8'h00, A));
    ex(o(4'd8, 8'h00, G | F | AND_));
    ex(o(4'd10, 8'h08, DONE));
    go("and_imm", 16'hD60F, 3'b000, 1'b1, 1'b0);

    ex(o(4'd4, 8'h00, A));
    ex(o(4'd6, 8'h00, F | SUB | DONE));
    go("cmp", 16'hE806, 3'b000, 1'b1, 1'b0);

    ex(o(4'd8, 8'h40, DONE));
    go("mvt", 16'h3CAB, 3'b000, 1'b1, 1'b0);

    ex(o(4'd0, 8'h00, DONE));
    go("bnv", 16'h2E00, 3'b111, 1'b1, 1'b0);

    ex(o(4'd7, 8'h00, A));
    ex(o(4'd8, 8'h00, G));
    ex(o(4'd10, 8'h80, DONE));
    go("bal", 16'h2000, 3'b000, 1'b1, 1'b0);

    ex(o(4'd7, 8'h00, A));
    ex(o(4'd8, 8'h00, G));
    ex(o(4'd10, 8'h80, DONE));
    go("bcs_t", 16'h2800, 3'b001, 1'b1, 1'b0);

    ex(o(4'd0, 8'h00, DONE));
    go("bcc_nt", 16'h2600, 3'b001, 1'b1, 1'b0);

    ex(o(4'd0, 8'h00, DONE));
    go("bmi_nt", 16'h2C00, 3'b000, 1'b1, 1'b0);

    ex(o(4'd0, 8'h00, DONE));
    go("bpl_nt", 16'h2A00, 3'b010, 1'b1, 1'b0);

    ex(o(4'd7, 8'h00, A));
    ex(o(4'd8, 8'h00, G));
    ex(o(4'd10, 8'h80, DONE));
    go("bne_t", 16'h2400, 3'b000, 1'b1, 1'b0);

    ex(o(4'd6, 8'h08, DONE));
    go("mv_reg", 16'h0606, 3'b000, 1'b1, 1'b0);

    ex(o(4'd8, 8'h80, DONE));
    go("mv_pc", 16'h1E01, 3'b000, 1'b1, 1'b0);

    // run dropped during E1: instruction completes, then IDLE.
    ex(o(4'd1, 8'h00, A));
    ex(o(4'd1, 8'h00, G | F));
    ex(o(4'd10, 8'h02, DONE));
    go("add_drop", 16'h4201, 3'b000, 1'b0, 1'b1);
    idle_cycles("after_drop", 3);

    @(negedge clk);
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", sbq.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
